// File: rtl/six_instr_ctrl_pkg.sv
// Shared definitions for the six-instruction processor: opcodes, control-unit
// state encodings and the register-file / ALU select codes. The datapath
// imports the same package so both sides agree on every encoding.
package six_instr_ctrl_pkg;

  // Opcode field values (ir[15:12])
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LOADC = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_JMPZ  = 4'b0101;

  // Control-unit states; encodings 10..15 are illegal and recover to INIT
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_LOADC  = 4'd6,
    S_SUB    = 4'd7,
    S_JMPZ   = 4'd8,
    S_JMP    = 4'd9
  } state_e;

  // Register-file write-data mux select
  localparam logic [1:0] RF_S_ALU   = 2'b00;
  localparam logic [1:0] RF_S_DMEM  = 2'b01;
  localparam logic [1:0] RF_S_CONST = 2'b10;

  // ALU operation select
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Opcode field of an instruction word
  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/six_instr_ctrl.sv
// Control unit for the six-instruction processor. A Moore FSM that walks
// INIT -> FETCH -> DECODE -> execute state -> FETCH, with every datapath
// strobe decoded from the current state and the IR contents.
module six_instr_ctrl
  import six_instr_ctrl_pkg::*;
#(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,        // active-low, asynchronous
  input  logic [15:0]        ir,
  input  logic               rf_rp_zero,
  output logic               pc_clr,
  output logic               pc_inc,
  output logic               pc_ld,
  output logic [DADDR_W-1:0] pc_offset,
  output logic               i_rd,
  output logic               ir_ld,
  output logic [DADDR_W-1:0] d_addr,
  output logic               d_rd,
  output logic               d_wr,
  output logic [DADDR_W-1:0] rf_w_data,
  output logic [1:0]         rf_s,
  output logic [RADDR_W-1:0] rf_w_addr,
  output logic               rf_w_wr,
  output logic [RADDR_W-1:0] rf_rp_addr,
  output logic               rf_rp_rd,
  output logic [RADDR_W-1:0] rf_rq_addr,
  output logic               rf_rq_rd,
  output logic [1:0]         alu_s
);

  state_e state_q;
  state_e state_d;

  // Instruction fields
  logic [3:0]         op;
  logic [RADDR_W-1:0] ra;
  logic [RADDR_W-1:0] rb;
  logic [RADDR_W-1:0] rc;
  logic [DADDR_W-1:0] imm;

  assign op  = opcode_of(ir);
  assign ra  = ir[11:8];
  assign rb  = ir[7:4];
  assign rc  = ir[3:0];
  assign imm = ir[7:0];

  // State register; reset forces INIT immediately so no write strobe survives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD:  state_d = S_LOAD;
          OP_STORE: state_d = S_STORE;
          OP_ADD:   state_d = S_ADD;
          OP_LOADC: state_d = S_LOADC;
          OP_SUB:   state_d = S_SUB;
          OP_JMPZ:  state_d = S_JMPZ;
          default:  state_d = S_FETCH;   // undefined opcode behaves as NOP
        endcase
      end
      S_LOAD:   state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_LOADC:  state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_JMPZ:   state_d = rf_rp_zero ? S_JMP : S_FETCH;
      S_JMP:    state_d = S_FETCH;
      default:  state_d = S_INIT;        // illegal encodings recover to INIT
    endcase
  end

  // Output decode; every strobe and field defaults to 0 when not used
  always_comb begin
    pc_clr     = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    pc_offset  = '0;
    i_rd       = 1'b0;
    ir_ld      = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_w_data  = '0;
    rf_s       = RF_S_ALU;
    rf_w_addr  = '0;
    rf_w_wr    = 1'b0;
    rf_rp_addr = '0;
    rf_rp_rd   = 1'b0;
    rf_rq_addr = '0;
    rf_rq_rd   = 1'b0;
    alu_s      = ALU_PASS;
    case (state_q)
      S_INIT: begin
        pc_clr = 1'b1;
      end
      S_FETCH: begin
        i_rd   = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      S_LOAD: begin
        d_addr    = imm;
        d_rd      = 1'b1;
        rf_s      = RF_S_DMEM;
        rf_w_addr = ra;
        rf_w_wr   = 1'b1;
      end
      S_STORE: begin
        d_addr     = imm;
        d_wr       = 1'b1;
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_rp_addr = rb;
        rf_rp_rd   = 1'b1;
        rf_rq_addr = rc;
        rf_rq_rd   = 1'b1;
        alu_s      = (state_q == S_SUB) ? ALU_SUB : ALU_ADD;
        rf_s       = RF_S_ALU;
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
      end
      S_LOADC: begin
        rf_w_data = imm;
        rf_s      = RF_S_CONST;
        rf_w_addr = ra;
        rf_w_wr   = 1'b1;
      end
      S_JMPZ: begin
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
      end
      S_JMP: begin
        pc_ld     = 1'b1;
        pc_offset = imm;
      end
      default: begin
        // DECODE and illegal encodings drive nothing
      end
    endcase
  end

endmodule

// File: tb/tb_six_instr_ctrl.sv
// Directed, table-driven bench for the six-instruction control unit.
module tb_six_instr_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic        rf_rp_zero;
  logic        pc_clr, pc_inc, pc_ld;
  logic [7:0]  pc_offset;
  logic        i_rd, ir_ld;
  logic [7:0]  d_addr;
  logic        d_rd, d_wr;
  logic [7:0]  rf_w_data;
  logic [1:0]  rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_wr;
  logic [3:0]  rf_rp_addr;
  logic        rf_rp_rd;
  logic [3:0]  rf_rq_addr;
  logic        rf_rq_rd;
  logic [1:0]  alu_s;

  six_instr_ctrl dut (
    .clk(clk), .reset(reset), .ir(ir), .rf_rp_zero(rf_rp_zero),
    .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_offset(pc_offset),
    .i_rd(i_rd), .ir_ld(ir_ld), .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr),
    .rf_w_data(rf_w_data), .rf_s(rf_s), .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr),
    .rf_rp_addr(rf_rp_addr), .rf_rp_rd(rf_rp_rd), .rf_rq_addr(rf_rq_addr),
    .rf_rq_rd(rf_rq_rd), .alu_s(alu_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_clr;
    logic       pc_inc;
    logic       pc_ld;
    logic [7:0] pc_offset;
    logic       i_rd;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_rd;
    logic       d_wr;
    logic [7:0] rf_w_data;
    logic [1:0] rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_wr;
    logic [3:0] rf_rp_addr;
    logic       rf_rp_rd;
    logic [3:0] rf_rq_addr;
    logic       rf_rq_rd;
    logic [1:0] alu_s;
  } outs_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic        zero;
    outs_t       exp;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Expected-output constructors, fields filled with hand-computed constants
  function automatic outs_t o_idle();
    outs_t o;
    o = '0;
    return o;
  endfunction

  function automatic outs_t o_init();
    outs_t o;
    o = '0;
    o.pc_clr = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_fetch();
    outs_t o;
    o = '0;
    o.i_rd = 1'b1; o.ir_ld = 1'b1; o.pc_inc = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_load(input logic [7:0] a, input logic [3:0] w);
    outs_t o;
    o = '0;
    o.d_addr = a; o.d_rd = 1'b1; o.rf_s = 2'b01; o.rf_w_addr = w; o.rf_w_wr = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_store(input logic [7:0] a, input logic [3:0] p);
    outs_t o;
    o = '0;
    o.d_addr = a; o.d_wr = 1'b1; o.rf_rp_addr = p; o.rf_rp_rd = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_alu(input logic [3:0] p, input logic [3:0] q,
                                  input logic [3:0] w, input logic [1:0] s);
    outs_t o;
    o = '0;
    o.rf_rp_addr = p; o.rf_rp_rd = 1'b1; o.rf_rq_addr = q; o.rf_rq_rd = 1'b1;
    o.alu_s = s; o.rf_s = 2'b00; o.rf_w_addr = w; o.rf_w_wr = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_loadc(input logic [7:0] c, input logic [3:0] w);
    outs_t o;
    o = '0;
    o.rf_w_data = c; o.rf_s = 2'b10; o.rf_w_addr = w; o.rf_w_wr = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_jmpz(input logic [3:0] p);
    outs_t o;
    o = '0;
    o.rf_rp_addr = p; o.rf_rp_rd = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_jmp(input logic [7:0] off);
    outs_t o;
    o = '0;
    o.pc_ld = 1'b1; o.pc_offset = off;
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t o;
    o = '{pc_clr, pc_inc, pc_ld, pc_offset, i_rd, ir_ld, d_addr, d_rd, d_wr,
          rf_w_data, rf_s, rf_w_addr, rf_w_wr, rf_rp_addr, rf_rp_rd,
          rf_rq_addr, rf_rq_rd, alu_s};
    return o;
  endfunction

  task automatic add_vec(input string nm, input logic [15:0] i, input logic z,
                         input outs_t e);
    vec_t v;
    v.name = nm; v.ir = i; v.zero = z; v.exp = e;
    vecs.push_back(v);
  endtask

  // Full output compare plus the PC-strobe and memory-strobe exclusion checks
  task automatic check(input string nm, input outs_t e);
    outs_t a;
    a = actual();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: outputs got %h expected %h", nm, a, e);
    end
    n_cmp++;
    if ($countones({pc_clr, pc_inc, pc_ld}) > 1) begin
      n_bad++;
      $display("FAIL %s_pc_excl: pc_clr/inc/ld got %b%b%b expected at most one set",
               nm, pc_clr, pc_inc, pc_ld);
    end
    n_cmp++;
    if (d_rd && d_wr) begin
      n_bad++;
      $display("FAIL %s_dmem_excl: d_rd/d_wr got %b%b expected not both",
               nm, d_rd, d_wr);
    end
  endtask

  initial begin
    // Each row describes one cycle: inputs applied, outputs expected in it
    add_vec("init",        16'h0000, 1'b0, o_init());
    add_vec("load_fetch",  16'h0012, 1'b0, o_fetch());
    add_vec("load_dec",    16'h0012, 1'b0, o_idle());
    add_vec("load_exec",   16'h0012, 1'b0, o_load(8'h12, 4'h0));
    add_vec("add_fetch",   16'h2123, 1'b0, o_fetch());
    add_vec("add_dec",     16'h2123, 1'b0, o_idle());
    add_vec("add_exec",    16'h2123, 1'b0, o_alu(4'h2, 4'h3, 4'h1, 2'b01));
    add_vec("sub_fetch",   16'h4123, 1'b0, o_fetch());
    add_vec("sub_dec",     16'h4123, 1'b0, o_idle());
    add_vec("sub_exec",    16'h4123, 1'b0, o_alu(4'h2, 4'h3, 4'h1, 2'b10));
    add_vec("loadc_fetch", 16'h3705, 1'b0, o_fetch());
    add_vec("loadc_dec",   16'h3705, 1'b0, o_idle());
    add_vec("loadc_exec",  16'h3705, 1'b0, o_loadc(8'h05, 4'h7));
    add_vec("store_fetch", 16'h1A40, 1'b0, o_fetch());
    add_vec("store_dec",   16'h1A40, 1'b0, o_idle());
    add_vec("store_exec",  16'h1A40, 1'b0, o_store(8'h40, 4'hA));
    add_vec("jz1_fetch",   16'h56FE, 1'b1, o_fetch());
    add_vec("jz1_dec",     16'h56FE, 1'b1, o_idle());
    add_vec("jz1_exec",    16'h56FE, 1'b1, o_jmpz(4'h6));
    add_vec("jz1_jmp",     16'h56FE, 1'b0, o_jmp(8'hFE));
    add_vec("jz0_fetch",   16'h56FE, 1'b0, o_fetch());
    add_vec("jz0_dec",     16'h56FE, 1'b1, o_idle());
    add_vec("jz0_exec",    16'h56FE, 1'b0, o_jmpz(4'h6));
    add_vec("nop_fetch",   16'hF000, 1'b0, o_fetch());
    add_vec("nop_dec",     16'hF000, 1'b1, o_idle());
    add_vec("after_nop",   16'h0012, 1'b1, o_fetch());
    add_vec("last_dec",    16'h0012, 1'b0, o_idle());
    add_vec("last_load",   16'h0012, 1'b0, o_load(8'h12, 4'h0));

    ir = 16'h0000;
    rf_rp_zero = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("in_reset", o_init());
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      ir = vecs[i].ir;
      rf_rp_zero = vecs[i].zero;
      #1;
      check(vecs[i].name, vecs[i].exp);
      @(negedge clk);
    end

    // Reset asserted in the middle of an ADD aborts it at once
    ir = 16'h2123;
    rf_rp_zero = 1'b0;
    #1 check("rst_fetch", o_fetch());
    @(negedge clk);
    #1 check("rst_dec", o_idle());
    @(negedge clk);
    #1 check("rst_add", o_alu(4'h2, 4'h3, 4'h1, 2'b01));
    #1 reset = 1'b0;
    #1 check("rst_async", o_init());
    @(negedge clk);
    #1 check("rst_hold", o_init());
    reset = 1'b1;
    #1 check("rst_release", o_init());
    @(negedge clk);
    #1 check("rst_then_fetch", o_fetch());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/six_instr_ctrl.md
Name: six_instr_ctrl

Overview:
- Control unit FSM for the six-instruction processor.
- Sequences PC, instruction memory, IR, data memory, register file and ALU through a fetch / decode / execute cycle.
- Takes the IR contents and the RF Rp-zero flag; drives every datapath control strobe.
- Sits between the IR output and the datapath; drives all datapath control inputs except the clock.

Parameters:
- DADDR_W, 8, data-memory address width and constant / offset field width (IR[7:0]).
- RADDR_W, 4, register-file address width.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- ir  input  16  IR data_out; op=ir[15:12], ra=ir[11:8], rb=ir[7:4], rc=ir[3:0], d/const/offset=ir[7:0]
- rf_rp_zero  input  1  1 when RF read port Rp currently reads zero
- pc_clr  output  1  clear PC to 0
- pc_inc  output  1  PC <= PC+1
- pc_ld  output  1  PC <= PC + sign-extended pc_offset - 1
- pc_offset  output  8  jump offset (ir[7:0])
- i_rd  output  1  instruction memory read enable
- ir_ld  output  1  IR load strobe
- d_addr  output  8  data memory address
- d_rd  output  1  data memory read
- d_wr  output  1  data memory write (data = RF Rp)
- rf_w_data  output  8  constant for LOADC (ir[7:0])
- rf_s  output  2  RF write mux: 00 ALU, 01 data memory, 10 constant
- rf_w_addr  output  4  RF write address
- rf_w_wr  output  1  RF write enable
- rf_rp_addr  output  4  RF read port P address
- rf_rp_rd  output  1  RF read port P enable
- rf_rq_addr  output  4  RF read port Q address
- rf_rq_rd  output  1  RF read port Q enable
- alu_s  output  2  00 pass A, 01 A+B, 10 A-B

Behaviour:
- Moore FSM; outputs decoded from the state register and ir only. Unlisted outputs are 0 in every state. Address and data fields are 0 when unused.
- States (4-bit): INIT, FETCH, DECODE, LOAD, STORE, ADD, LOADC, SUB, JMPZ, JMP.
- Reset (reset=0, async): state <= INIT immediately. Outputs become INIT values: pc_clr=1, all others 0. Reset mid-instruction aborts the instruction; no partial writes occur after reset asserts.
- INIT: pc_clr=1 -> FETCH.
- FETCH: i_rd=1, ir_ld=1, pc_inc=1 -> DECODE. IR holds the new instruction from DECODE onward.
- DECODE: no strobes. op 0000->LOAD, 0001->STORE, 0010->ADD, 0011->LOADC, 0100->SUB, 0101->JMPZ. Any other op -> FETCH, acting as a NOP.
- LOAD: d_addr=ir[7:0], d_rd=1, rf_s=01, rf_w_addr=ra, rf_w_wr=1 -> FETCH.
- STORE: d_addr=ir[7:0], d_wr=1, rf_rp_addr=ra, rf_rp_rd=1 -> FETCH.
- ADD: rf_rp_addr=rb, rf_rp_rd=1, rf_rq_addr=rc, rf_rq_rd=1, alu_s=01, rf_s=00, rf_w_addr=ra, rf_w_wr=1 -> FETCH.
- SUB: same as ADD with alu_s=10 -> FETCH.
- LOADC: rf_w_data=ir[7:0], rf_s=10, rf_w_addr=ra, rf_w_wr=1 -> FETCH.
- JMPZ: rf_rp_addr=ra, rf_rp_rd=1. rf_rp_zero=1 -> JMP, else FETCH. Sampled at the clock edge leaving JMPZ.
- JMP: pc_ld=1, pc_offset=ir[7:0] -> FETCH.
- Latency: 3 cycles per instruction; taken JMPZ takes 4.
- Mutual exclusion: pc_clr, pc_inc and pc_ld are never asserted together. d_rd and d_wr are never asserted together.
- Illegal state encodings -> INIT on the next edge.

Decomposition:
- Shared include file holds:
  - opcode localparams OP_LOAD..OP_JMPZ;
  - state encodings;
  - rf_s and alu_s select constants.
- The datapath uses the same file.
- Single module; no sub-module. The next-state and output decode are two always blocks in the same file.

Test Plan:
- Reset asserted (reset=0) mid-ADD -> state INIT immediately, rf_w_wr=0, pc_clr=1. Release -> FETCH on the next edge.
- ir=16'h0012 (LOAD R0,D[0x12]) -> FETCH, DECODE, LOAD in 3 cycles; in LOAD, d_addr=0x12, d_rd=1, rf_s=01, rf_w_addr=0, rf_w_wr=1.
- ir=16'h2123 (ADD R1=R2+R3) -> in ADD, rp=2, rq=3, alu_s=01, rf_w_addr=1, rf_w_wr=1. Then ir=16'h4123 -> same with alu_s=10.
- ir=16'h3705 (LOADC R7,#5) -> rf_w_data=0x05, rf_s=10, rf_w_addr=7. Then ir=16'h1A40 (STORE D[0x40],RA) -> d_wr=1, d_addr=0x40, rf_rp_addr=0xA.
- ir=16'h56FE (JMPZ R6,-2) with rf_rp_zero=1 -> JMP with pc_ld=1, pc_offset=0xFE, 4 cycles total. With rf_rp_zero=0 -> FETCH after 3 cycles, pc_ld never asserted.
- ir=16'hF000 (undefined op) -> DECODE->FETCH with no RF or data-memory write. Across all scenarios, assert at most one PC strobe per cycle.
